// File: rtl/mem_pkg.sv
// Shared access-size encodings, LSU state type and alignment helper for the
// data RAM load/store path.
package mem_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned SIZE_W = 2;

  localparam logic [SIZE_W-1:0] SIZE_BYTE      = 2'b00;
  localparam logic [SIZE_W-1:0] SIZE_HALF_WORD = 2'b01;
  localparam logic [SIZE_W-1:0] SIZE_WORD      = 2'b10;
  localparam logic [SIZE_W-1:0] SIZE_ILLEGAL   = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    RD_WAIT,
    RSP
  } lsu_state_t;

  // True when the low address bits violate natural alignment for the size.
  function automatic logic size_misaligned(input logic [SIZE_W-1:0] size,
                                           input logic [1:0]        addr_lo);
    logic mis;
    mis = 1'b0;
    case (size)
      SIZE_HALF_WORD: mis = addr_lo[0];
      SIZE_WORD:      mis = (addr_lo != 2'b00);
      default:        mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/lsu_load_fmt.sv
// Load data formatter: picks the low byte/half/word of the RAM read data and
// zero- or sign-extends it to 32 bits.
module lsu_load_fmt
  import mem_pkg::*;
(
  input  logic [DATA_W-1:0] i_mem_dout,
  input  logic [SIZE_W-1:0] i_size,
  input  logic              i_unsigned,
  output logic [DATA_W-1:0] o_rdata_c
);

  logic ext_b;
  logic ext_h;

  assign ext_b = ~i_unsigned & i_mem_dout[7];
  assign ext_h = ~i_unsigned & i_mem_dout[15];

  always_comb begin
    o_rdata_c = i_mem_dout;
    case (i_size)
      SIZE_BYTE:      o_rdata_c = {{24{ext_b}}, i_mem_dout[7:0]};
      SIZE_HALF_WORD: o_rdata_c = {{16{ext_h}}, i_mem_dout[15:0]};
      default:        o_rdata_c = i_mem_dout;
    endcase
  end

endmodule

// File: rtl/lsu_mem_port.sv
// Single-outstanding load/store initiator for one data RAM port: checks the
// request, drives the RAM, formats load data and returns one response.
module lsu_mem_port
  import mem_pkg::*;
#(
  parameter int unsigned MEM_DEPTH      = 4096,
  parameter int unsigned MEM_ADDR_WIDTH = 12
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_req_valid,
  output logic                      o_req_ready,
  input  logic                      i_req_we,
  input  logic [1:0]                i_req_size,
  input  logic                      i_req_unsigned,
  input  logic [31:0]               i_req_addr,
  input  logic [31:0]               i_req_wdata,
  output logic                      o_rsp_valid,
  input  logic                      i_rsp_ready,
  output logic [31:0]               o_rsp_rdata,
  output logic                      o_rsp_err,
  output logic [MEM_ADDR_WIDTH-1:0] o_mem_addr,
  output logic                      o_mem_we,
  output logic [1:0]                o_mem_size,
  output logic [31:0]               o_mem_din,
  input  logic [31:0]               i_mem_dout
);

  if (MEM_DEPTH != (32'd1 << MEM_ADDR_WIDTH)) begin : g_depth_chk
    $error("MEM_DEPTH must equal 2**MEM_ADDR_WIDTH");
  end

  lsu_state_t                state_q, state_d;
  logic [MEM_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [SIZE_W-1:0]         size_q, size_d;
  logic                      uns_q, uns_d;
  logic                      rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]         rdata_q, rdata_d;
  logic                      err_q, err_d;

  logic                      accept_c;
  logic                      req_err_c;
  logic [DATA_W-1:0]         fmt_c;

  assign o_req_ready = (state_q == IDLE) && i_rst_n;
  assign accept_c    = i_req_valid && o_req_ready;

  // Upper address bits must be zero; aligned in-range accesses never cross the top.
  assign req_err_c = (i_req_size == SIZE_ILLEGAL)
                   || size_misaligned(i_req_size, i_req_addr[1:0])
                   || (|i_req_addr[31:MEM_ADDR_WIDTH]);

  lsu_load_fmt u_load_fmt (
    .i_mem_dout (i_mem_dout),
    .i_size     (size_q),
    .i_unsigned (uns_q),
    .o_rdata_c  (fmt_c)
  );

  // RAM port: follows the request in IDLE so stores land on the accept edge.
  always_comb begin
    o_mem_addr = addr_q;
    o_mem_size = size_q;
    o_mem_din  = '0;
    o_mem_we   = 1'b0;
    if (!i_rst_n) begin
      o_mem_addr = '0;
      o_mem_size = SIZE_WORD;
    end else if (state_q == IDLE) begin
      o_mem_addr = i_req_addr[MEM_ADDR_WIDTH-1:0];
      o_mem_size = i_req_size;
      o_mem_din  = i_req_wdata;
      o_mem_we   = accept_c && i_req_we && !req_err_c;
    end
  end

  // Next-state and response register update.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    size_d      = size_q;
    uns_d       = uns_q;
    rsp_valid_d = rsp_valid_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    case (state_q)
      IDLE: begin
        if (accept_c) begin
          addr_d  = i_req_addr[MEM_ADDR_WIDTH-1:0];
          size_d  = i_req_size;
          uns_d   = i_req_unsigned;
          rdata_d = '0;
          err_d   = req_err_c;
          if (req_err_c || i_req_we) begin
            state_d     = RSP;
            rsp_valid_d = 1'b1;
          end else begin
            state_d = RD_WAIT;
          end
        end
      end
      RD_WAIT: begin
        rdata_d     = fmt_c;
        err_d       = 1'b0;
        state_d     = RSP;
        rsp_valid_d = 1'b1;
      end
      RSP: begin
        if (i_rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
        end
      end
      default: begin
        state_d     = IDLE;
        rsp_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      size_q      <= SIZE_WORD;
      uns_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      rsp_valid_q <= rsp_valid_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
    end
  end

  assign o_rsp_valid = rsp_valid_q;
  assign o_rsp_rdata = rdata_q;
  assign o_rsp_err   = err_q;

endmodule

// File: doc/lsu_mem_port.md
# lsu_mem_port

Load/store initiator for one port of the byte-addressed, little-endian data RAM. Accepts single load/store requests from the core over a valid/ready handshake. Checks alignment and range, then drives the RAM port's address, write-enable, size and data. For loads it waits out the RAM's one-cycle registered read, then zero- or sign-extends the returned data. Every request produces exactly one response, including stores and faulting requests.

## Interface
Parameters:
- MEM_DEPTH, 4096, RAM size in bytes; always equals 2**MEM_ADDR_WIDTH
- MEM_ADDR_WIDTH, 12, RAM byte-address width

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  reset, asynchronous assert, active-low
- i_req_valid  in  1  request valid
- o_req_ready  out  1  request accepted when valid && ready
- i_req_we  in  1  1 = store, 0 = load
- i_req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- i_req_unsigned  in  1  load zero-extends; ignored for word loads and for stores
- i_req_addr  in  32  byte address
- i_req_wdata  in  32  store data, right-justified
- o_rsp_valid  out  1  response valid
- i_rsp_ready  in  1  response consumed when valid && ready
- o_rsp_rdata  out  32  load result; 0 for stores and errors
- o_rsp_err  out  1  misaligned, out-of-range or illegal size
- o_mem_addr  out  MEM_ADDR_WIDTH  RAM address
- o_mem_we  out  1  RAM write enable
- o_mem_size  out  2  RAM access size
- o_mem_din  out  32  RAM write data
- i_mem_dout  in  32  RAM read data; {mem[a+3..a]} registered one clock after the address

## Operation
- FSM states: IDLE, RD_WAIT, RSP.
- o_req_ready = (state == IDLE) && i_rst_n.
- Error check, evaluated at accept:
  - size 11 → error
  - half with addr[0] set → error
  - word with addr[1:0] ≠ 0 → error
  - i_req_addr[31:MEM_ADDR_WIDTH] ≠ 0 → error
  - Aligned in-range accesses cannot cross the top of the RAM, so no further range check is needed.
- Memory outputs in IDLE:
  - o_mem_addr = i_req_addr[MEM_ADDR_WIDTH-1:0]
  - o_mem_size = i_req_size
  - o_mem_din = i_req_wdata, unmodified; the RAM stores only the low bytes for the given size
  - o_mem_we = accept && i_req_we && !error
- Memory outputs in other states: o_mem_addr holds the latched address, o_mem_we = 0.
- Transitions on accept:
  - error → RSP, with err = 1 and rdata = 0; the RAM is never written
  - store → RSP, with err = 0 and rdata = 0
  - load → RD_WAIT; size and unsigned flag are latched
- RD_WAIT: format i_mem_dout into the response registers, then → RSP.
  - byte: low 8 bits, bit 7 extended when signed
  - half: low 16 bits, bit 15 extended when signed
  - word: all 32 bits unchanged
- RSP: o_rsp_valid = 1; rdata and err are held stable. On i_rsp_ready → IDLE.
- Only one request is outstanding at a time. A new request is never accepted in the same cycle a response retires.

## Timing
- Reset values (async, while i_rst_n = 0):
  - state IDLE
  - o_rsp_valid 0, o_rsp_rdata 0, o_rsp_err 0
  - o_req_ready 0, o_mem_we 0
  - o_mem_addr 0, o_mem_size 10, o_mem_din 0
- Load accepted at edge N: o_rsp_valid high after edge N+2.
- Store or error accepted at edge N: o_rsp_valid high after edge N+1.
- A store's RAM write occurs at edge N itself.
- With i_rsp_ready tied high:
  - one load every 3 cycles
  - one store every 2 cycles
- Backpressure: the RSP state holds indefinitely, and o_req_ready stays 0 throughout.
- Reset mid-operation: the in-flight request is dropped and no response is produced. A store whose accept edge has already passed remains written.

## Structure
- Package mem_pkg holds:
  - SIZE_BYTE, SIZE_HALF_WORD, SIZE_WORD constants
  - enum lsu_state_t {IDLE, RD_WAIT, RSP}
  - function size_misaligned(size, addr[1:0])
- One sub-module: lsu_load_fmt, a combinational block (i_mem_dout, size, unsigned) → 32-bit formatted result.
- The top level holds the FSM, the error check, the request latch and the response registers.

## Test plan
- Word store 0xDEADBEEF @0x100, then word load @0x100 → rdata 0xDEADBEEF, err 0, rsp_valid exactly 2 edges after accept.
- Byte loads @0x103 after the step above: signed → 0xFFFFFFDE; unsigned → 0x000000DE.
- Word 0x11223344 preloaded @0x200, half store 0x8001 @0x200 → word load 0x11228001; signed half load @0x200 → 0xFFFF8001; unsigned → 0x00008001.
- Errors, each giving err 1, rdata 0, o_mem_we never high, rsp 1 edge after accept, and RAM contents unchanged:
  - word store @0x102
  - half load @0x201
  - word load @0x1000
  - size 11
- Backpressure: i_rsp_ready low for 5 cycles after a load → rsp_valid and rdata stable, o_req_ready 0, a concurrently presented request is not accepted until the cycle after retirement.
- Reset pulsed during RD_WAIT → all outputs at reset values, no rsp_valid after release, next request completes normally.
